// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared constants and types for the 1:4 stream demux
package stream_demux_pkg;
  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 8;

  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/demux1x2_stage.sv
// rtl/demux1x2_stage.sv - single-entry registered 1:2 demux stage with valid/ready
module demux1x2_stage
  import stream_demux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_valid,
  input  logic [1:0]    out_ready
);
  logic          full_q;
  logic          sel_q;
  logic [DW-1:0] data_q;

  // Accept when empty or when the held beat is leaving this same edge.
  assign in_ready  = !full_q || out_ready[sel_q];
  assign out_valid = {full_q && sel_q, full_q && !sel_q};
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      sel_q  <= 1'b0;
      data_q <= '0;
    end else if (in_valid && in_ready) begin
      full_q <= 1'b1;
      sel_q  <= in_sel;
      data_q <= in_data;
    end else if (full_q && out_ready[sel_q]) begin
      full_q <= 1'b0;
    end
  end
endmodule

// File: rtl/stream_demux1x4.sv
// rtl/stream_demux1x4.sv - registered 1:4 stream demux as a two-level tree of 1:2 stages
// Optional per-channel delivery counters: STREAM_DEMUX_STATS_EN
module stream_demux1x4
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0]                  in_data,
  input  logic [SEL_W-1:0]                  in_sel,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [NUM_OUT-1:0][WIDTH-1:0]     out_data,
  output logic [NUM_OUT-1:0]                out_valid,
  input  logic [NUM_OUT-1:0]                out_ready
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output cnt_t [NUM_OUT-1:0]                out_count
`endif
);
  logic [WIDTH:0] l0_data;
  logic [1:0]     l0_valid;
  logic [1:0]     l0_ready;

  // Level 0 splits on the high sel bit and carries the low bit with the payload.
  demux1x2_stage #(.DW(WIDTH + 1)) u_l0 (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({in_sel[0], in_data}),
    .in_sel    (in_sel[1]),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (l0_data),
    .out_valid (l0_valid),
    .out_ready (l0_ready)
  );

  for (genvar b = 0; b < 2; b++) begin : g_l1
    logic [WIDTH-1:0] l1_data;

    demux1x2_stage #(.DW(WIDTH)) u_l1 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (l0_data[WIDTH-1:0]),
      .in_sel    (l0_data[WIDTH]),
      .in_valid  (l0_valid[b]),
      .in_ready  (l0_ready[b]),
      .out_data  (l1_data),
      .out_valid (out_valid[2*b+1:2*b]),
      .out_ready (out_ready[2*b+1:2*b])
    );

    assign out_data[2*b]   = l1_data;
    assign out_data[2*b+1] = l1_data;
  end

`ifdef STREAM_DEMUX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (out_valid[i] && out_ready[i]) out_count[i] <= out_count[i] + cnt_t'(1);
      end
    end
  end
`endif
endmodule

// File: tb/tb_stream_demux1x4.sv
// tb/tb_stream_demux1x4.sv - randomized scoreboard bench for stream_demux1x4
// Counter checks are active when STREAM_DEMUX_STATS_EN is defined.
module tb_stream_demux1x4;
  bit               clk;
  logic             rst;
  logic [7:0]       in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [3:0][7:0]  out_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
`ifdef STREAM_DEMUX_STATS_EN
  logic [3:0][7:0]  out_count;
`endif

  stream_demux1x4 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .out_count (out_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference: per-channel FIFO of accepted payloads and their acceptance cycle.
  logic [7:0] exp_q [4][$];
  int         acc_q [4][$];
  logic [7:0] mcnt [4];
  int         n1;
  bit         lat_mode;
  logic [3:0] last_ov;
  logic       last_ir;
  logic       last_acc;
  logic [7:0] last_od2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      acc_q[i].delete();
      mcnt[i] = 8'd0;
    end
    n1 = 0;
  endtask

  task automatic cycle();
    logic [7:0] e;
    int         a;
    bit         hit255;
    hit255 = 1'b0;
    @(negedge clk);
    last_ov  = out_valid;
    last_ir  = in_ready;
    last_od2 = out_data[2];
    last_acc = 1'b0;
    if (rst) begin
      model_clear();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("spurious_ch%0d", i), 1, 0);
          end else begin
            e = exp_q[i].pop_front();
            a = acc_q[i].pop_front();
            chk($sformatf("data_ch%0d", i), out_data[i], e);
            if (lat_mode) chk($sformatf("latency_ch%0d", i), cyc - a, 2);
            mcnt[i] = mcnt[i] + 8'd1;
            if (i == 1) begin
              n1++;
              if (n1 == 255) hit255 = 1'b1;
            end
          end
        end
      end
      last_acc = in_valid && in_ready;
      if (last_acc) begin
        exp_q[in_sel].push_back(in_data);
        acc_q[in_sel].push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
`ifdef STREAM_DEMUX_STATS_EN
    for (int i = 0; i < 4; i++) chk($sformatf("count_ch%0d", i), out_count[i], mcnt[i]);
    if (hit255) chk("count1_at_255", out_count[1], 8'd255);
`else
    if (hit255) n1 = n1;
`endif
  endtask

  task automatic send(input logic [1:0] s, input logic [7:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (last_acc) break;
    end
    chk("send_accept", last_acc, 1);
    in_valid = 1'b0;
  endtask

  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
  endfunction

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 4'hF;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    lat_mode  = 1'b1;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 8'h5A;
    out_ready = 4'hF;

    // Reset with a beat offered.
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("reset_ov", last_ov, 4'b0000);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    cycle();
    chk("reset_in_ready", last_ir, 1);
    chk("reset_ov_after", last_ov, 4'b0000);

    // Single beat: visible on channel 2 only in cycle c+2.
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
    cycle();
    chk("single_acc", last_acc, 1);
    in_valid = 1'b0;
    cycle();
    chk("single_c1_ov", last_ov, 4'b0000);
    cycle();
    chk("single_c2_ov", last_ov, 4'b0100);
    chk("single_c2_data", last_od2, 8'hA5);
    cycle();
    chk("single_c3_ov", last_ov, 4'b0000);

    // Back-to-back to all four channels.
    for (int j = 0; j < 8; j++) begin
      in_valid = (j < 4);
      in_sel   = 2'(j);
      in_data  = 8'h10 + 8'(j);
      cycle();
      if (j < 4) chk("b2b_acc", last_acc, 1);
      chk($sformatf("b2b_ov_%0d", j), last_ov,
          (j >= 2 && j <= 5) ? (32'd1 << (j - 2)) : 32'd0);
    end
    chk("b2b_empty", pending(), 0);

    // Head-of-line blocking behind a stalled channel 3.
    lat_mode  = 1'b0;
    out_ready = 4'b0111;
    send(2'd3, 8'hA1);
    send(2'd2, 8'hB2);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hC3;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hol_in_ready", last_ir, 0);
      chk("hol_ov", last_ov, 4'b1000);
    end
    out_ready = 4'hF;
    send(2'd0, 8'hC3);
    drain(6);
    chk("hol_empty", pending(), 0);

    // Mid-flight reset discards two beats.
    lat_mode = 1'b1;
    send(2'd0, 8'h31);
    send(2'd3, 8'h32);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("midrst_ov0", last_ov, 4'b0000);
    cycle();
    chk("midrst_ov1", last_ov, 4'b0000);
    send(2'd1, 8'h55);
    drain(4);
    chk("midrst_empty", pending(), 0);

    // Randomized traffic with random backpressure.
    lat_mode = 1'b0;
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      in_sel    = 2'($urandom_range(3, 0));
      in_data   = 8'($urandom);
      for (int i = 0; i < 4; i++) out_ready[i] = ($urandom_range(3, 0) != 0);
      cycle();
    end
    drain(12);
    chk("rand_empty", pending(), 0);

    // 256 transfers to channel 1 from a fresh reset.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    lat_mode  = 1'b1;
    out_ready = 4'hF;
    begin
      int sent;
      sent = 0;
      in_sel = 2'd1;
      for (int k = 0; k < 400 && sent < 256; k++) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        cycle();
        if (last_acc) sent++;
      end
      chk("stats_sent", sent, 256);
    end
    drain(6);
    chk("stats_delivered", n1, 256);
    chk("stats_empty", pending(), 0);
`ifdef STREAM_DEMUX_STATS_EN
    chk("count1_wrapped", out_count[1], 8'd0);
    chk("count0_zero", out_count[0], 8'd0);
    chk("count2_zero", out_count[2], 8'd0);
    chk("count3_zero", out_count[3], 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_demux1x4.md
# stream_demux1x4

Registered 1:4 stream demultiplexer with valid/ready handshakes. It steers each input beat to one of four output channels selected by a 2-bit tag. It is the distribution counterpart of the structural 4:1 mux, built as a two-level tree of 1:2 demux stages. It sits between a single producer and four independent consumers.

## Interface
- WIDTH, 8, payload width in bits
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  payload
- in_sel  input  2  destination channel 0..3
- in_valid  input  1  producer offers beat
- in_ready  output  1  block accepts beat this cycle
- out_data  output  4×WIDTH (packed [3:0][WIDTH-1:0])  per-channel payload
- out_valid  output  4  per-channel valid
- out_ready  input  4  per-channel consumer ready
- out_count  output  4×8  per-channel delivered-beat counters (only with STREAM_DEMUX_STATS_EN)

## Operation
- A transfer occurs when valid&&ready are both high at a rising edge. This applies on the input side and on each output channel.
- Level 0 is one stage.
  - It splits on in_sel[1].
  - It carries {in_sel[0], in_data} as its payload.
- Level 1 is two stages.
  - Branch 0 serves channels 0/1 and branch 1 serves channels 2/3.
  - Each splits on the carried sel bit.
- Each stage is a single-entry register holding full_q, sel_q and data_q.
  - Stage out_valid[i] = full_q && (sel_q == i).
  - Both stage outputs drive data_q; valid alone qualifies the data.
  - Stage in_ready = !full_q || downstream_ready[sel_q].
  - On an input transfer, the stage loads data and sel and sets full_q. It may load in the same cycle the held beat leaves.
  - If the held beat leaves and no new beat arrives, full_q clears.
- Ordering:
  - Beats to the same channel leave in acceptance order.
  - A stalled channel blocks any later beat that must pass the same occupied stage (head-of-line blocking). Beats on the other level-0 branch are unaffected once they pass level 0.
- A beat is never dropped or duplicated, except when reset discards it.
- Reset values:
  - All full_q, sel_q and data_q are 0.
  - out_valid = 4'b0000 and out_data = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset during operation: every in-flight beat is discarded. No output valid is asserted in the cycle after rst is sampled high.

## Timing
- Latency: a beat accepted in cycle c is presented on out_valid[in_sel] in cycle c+2 if no stall occurs.
- Throughput: one beat per cycle when the destination channels are ready.
- The ready path is combinational: out_ready → level-1 in_ready → level-0 in_ready → in_ready. This is 2 stage-levels deep; there is no ready register.
- All valid and data outputs are registered; none depend combinationally on in_valid.

## Configuration
- STREAM_DEMUX_STATS_EN defined:
  - The out_count port exists.
  - out_count[i] increments by 1 on each out_valid[i]&&out_ready[i] transfer.
  - It wraps from 255 to 0 and resets to 0.
- Not defined:
  - The port and counters are absent.
  - The datapath behaves identically.

## Structure
- The package stream_demux_pkg contains:
  - NUM_OUT = 4, SEL_W = 2, CNT_W = 8
  - typedef cnt_t (logic [CNT_W-1:0])
- The natural sub-module is demux1x2_stage. Its parameter DW is the payload width.
  - Level 0 instantiates it with DW = WIDTH+1.
  - Level 1 instantiates it with DW = WIDTH.
  - Its ports are clk, rst, in_data, in_sel, in_valid, in_ready, out_data, out_valid[1:0], out_ready[1:0].
- The top level contains only the three instances, the level-0 payload pack/unpack, and the optional counters.

## Test plan
- Reset:
  - Stimulus: rst high 2 cycles, in_valid=1.
  - Response: out_valid=0000 throughout; in_ready=1 after release; out_count all 0.
- Single beat:
  - Stimulus: in_data=0xA5, in_sel=2, accepted cycle c, out_ready=1111.
  - Response: out_valid=0100 with out_data[2]=0xA5 in cycle c+2 only.
- Back-to-back:
  - Stimulus: sel 0,1,2,3 with data 0x10..0x13 on consecutive cycles, all ready.
  - Response: channels 0..3 each valid for one cycle, in cycles c+2..c+5, with matching data.
- Backpressure / head-of-line blocking:
  - Stimulus: out_ready[3]=0; send A(sel3), B(sel2), C(sel0).
  - Response: in_ready low while C is offered. Raise out_ready[3]: A exits ch3, then B exits ch2 and C exits ch0. No beat is lost.
- Mid-flight reset:
  - Stimulus: 2 beats in flight, rst for 1 cycle.
  - Response: no out_valid afterwards; a new beat after release arrives 2 cycles after acceptance.
- STREAM_DEMUX_STATS_EN:
  - Stimulus: 256 transfers to channel 1.
  - Response: out_count[1] reads 255 after the 255th transfer and 0 after the 256th; other counters stay 0.
